wave_diff_tracker: RTL and testbench
====================================

Name: wave_diff_tracker

Overview:
Parametrised lag-N first-difference filter for the oscilloscope capture path. Consumes the ADC sample stream (valid-qualified) and emits a mid-scale-offset difference of each sample against the sample L positions earlier. Difference is saturating. Also emits slope-based peak/trough pulses and a peak-to-peak period count. Sits between capture and the waveform-match (ai_match) logic; supersedes the fixed lag-1, wrapping differentiator.

Parameters:
DATA_W, 8, sample and difference output width.
LAG_MAX, 16, depth of lag ring buffer; max supported lag.
HYST, 4, slope hysteresis threshold in LSBs (raw signed difference).
PERIOD_W, 16, width of period counter/output.

Ports:
clk_50M  in  1  system clock.
rst_n  in  1  reset; synchronous, active-low; clock clk_50M.
valid_in  in  1  wave_data is a new sample this cycle.
wave_data  in  DATA_W  unsigned sample.
lag  in  $clog2(LAG_MAX+1)  difference distance L; sampled only in IDLE.
invert  in  1  1: out = delayed - current (legacy polarity); 0: current - delayed.
restart_on_gap  in  1  1: valid_in low aborts burst and refills; 0: gap holds state.
diff_out  out  DATA_W  saturated offset difference.
diff_valid  out  1  one-cycle pulse per output sample.
sat_flag  out  1  diff_out clamped this sample; qualified by diff_valid.
peak_flag  out  1  rising-to-falling slope transition; qualified by diff_valid.
trough_flag  out  1  falling-to-rising slope transition; qualified by diff_valid.
period_out  out  PERIOD_W  accepted samples between consecutive peaks.
period_valid  out  1  one-cycle pulse, coincident with peak_flag when a prior peak exists.

Behaviour:
- Reset: all outputs 0; state IDLE; write pointer, fill count, slope state (UNKNOWN), period counter and have_peak cleared. Ring contents are don't-care because the fill count gates them. Reset mid-burst takes effect at the next edge, and the next burst must fully refill.
- States:
  - IDLE: on valid_in, latch L_eff = clamp(lag, 1, LAG_MAX), with 0 treated as 1. Store the sample and go to FILL.
  - FILL: store each accepted sample. Go to RUN once L_eff+1 samples have been accepted. Output begins on that sample.
  - RUN: every accepted sample produces an output.
- Ring buffer: LAG_MAX entries, write pointer wraps mod LAG_MAX. Delayed sample = buf[(wr_ptr - L_eff) mod LAG_MAX], read before the same-cycle write, so L_eff = LAG_MAX reads the slot about to be overwritten. lag changes during FILL/RUN are ignored until the next IDLE.
- Latency: a sample accepted at edge t gives diff_out, diff_valid and the flags at edge t+1. diff_valid deasserts on any cycle without an accepted output sample.
- Arithmetic:
  - d_raw = cur - delayed, signed DATA_W+1 bits.
  - d = invert ? -d_raw : d_raw.
  - r = d + 2^(DATA_W-1).
  - r < 0 gives diff_out 0, sat_flag 1. r > 2^DATA_W - 1 gives all-ones, sat_flag 1. Otherwise diff_out = r, sat_flag 0.
- Slope FSM (uses d_raw, independent of invert):
  - d_raw > HYST sets slope RISING; d_raw < -HYST sets FALLING; otherwise slope unchanged.
  - RISING to FALLING pulses peak_flag; FALLING to RISING pulses trough_flag.
  - A transition out of UNKNOWN raises no flag.
- Period counter: increments per accepted sample in RUN and saturates at all-ones.
  - On peak with have_peak = 1: period_out = count, pulse period_valid.
  - On every peak: count reset to 1, have_peak set.
- Gap (valid_in low in FILL/RUN):
  - restart_on_gap = 1: go to IDLE and clear fill count, slope, period counter and have_peak.
  - restart_on_gap = 0: state, buffer and counters held; the next sample continues seamlessly.
- valid_in in IDLE with restart pending: that sample starts the new fill (no dropped sample).

Decomposition:
- Package wave_dsp_pkg:
  - state enum (IDLE, FILL, RUN);
  - slope enum (UNKNOWN, RISING, FALLING);
  - MID_SCALE(DATA_W) constant function;
  - saturating clamp function.
- Sub-module lag_ring_buffer:
  - parameters DATA_W, LAG_MAX; ports write enable/data, L_eff, delayed read;
  - owns the pointer and wrap arithmetic.

Test Plan:
1. lag=1, invert=1, samples 100,90,95 -> first sample no output; then diff_out 138, 123 with sat_flag 0, each one cycle after its input.
2. lag=1, invert=0, samples 0,255,0 -> diff_out 255 with sat_flag 1, then 0 with sat_flag 1.
3. lag=4, LAG_MAX=16, ramp 0,5,10,... for 40 samples -> first diff_valid on the 5th sample; diff_out 148 constant across pointer wrap.
4. lag=2, gap after 3 samples: restart_on_gap=1 -> first post-gap output on the 3rd new sample; restart_on_gap=0 -> first post-gap sample outputs immediately against pre-gap history.
5. lag=1, HYST=4, triangle 0..200..0 step 20 (period 20) for 3 cycles -> peak_flag on each 200→180 step; period_valid with period_out=20 from the 2nd peak; trough_flag on each 0→20 step after the first peak.
6. rst_n low one cycle mid-RUN -> all outputs 0 next cycle; lag=3 burst then needs 4 samples before the next diff_valid.

Source files
------------

// File: rtl/wave_dsp_pkg.sv
// Shared types and arithmetic helpers for the waveform difference path.
package wave_dsp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        UNKNOWN,
        RISING,
        FALLING
    } slope_t;

    function automatic int MID_SCALE(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    // Clamp a signed intermediate result into the unsigned output range [0, hi].
    function automatic int sat_clamp(input int value, input int hi);
        if (value < 0) begin
            return 0;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/lag_ring_buffer.sv
// Circular sample history; returns the sample written L_eff writes ago,
// read before this cycle's write lands.
module lag_ring_buffer #(
    parameter int DATA_W  = 8,
    parameter int LAG_MAX = 16
) (
    input  logic                             clk_50M,
    input  logic                             rst_n,
    input  logic                             i_wr_en,
    input  logic [DATA_W-1:0]                i_wr_data,
    input  logic [$clog2(LAG_MAX+1)-1:0]     i_lag_eff,
    output logic [DATA_W-1:0]                o_rd_data
);

    localparam int PTR_W = (LAG_MAX > 1) ? $clog2(LAG_MAX) : 1;

    logic [DATA_W-1:0] r_mem [LAG_MAX];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  w_rd_idx;

    // Modulo subtraction done explicitly so non-power-of-two depths wrap correctly.
    always_comb begin
        w_rd_idx = '0;
        if (int'(r_wr_ptr) >= int'(i_lag_eff)) begin
            w_rd_idx = PTR_W'(int'(r_wr_ptr) - int'(i_lag_eff));
        end else begin
            w_rd_idx = PTR_W'(int'(r_wr_ptr) + LAG_MAX - int'(i_lag_eff));
        end
    end

    assign o_rd_data = r_mem[w_rd_idx];

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            if (r_wr_ptr == PTR_W'(LAG_MAX - 1)) begin
                r_wr_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/wave_diff_tracker.sv
// Lag-N saturating first-difference filter with slope peak/trough detection
// and peak-to-peak period measurement for the capture path.
module wave_diff_tracker
    import wave_dsp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LAG_MAX  = 16,
    parameter int HYST     = 4,
    parameter int PERIOD_W = 16
) (
    input  logic                         clk_50M,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic [DATA_W-1:0]            wave_data,
    input  logic [$clog2(LAG_MAX+1)-1:0] lag,
    input  logic                         invert,
    input  logic                         restart_on_gap,
    output logic [DATA_W-1:0]            diff_out,
    output logic                         diff_valid,
    output logic                         sat_flag,
    output logic                         peak_flag,
    output logic                         trough_flag,
    output logic [PERIOD_W-1:0]          period_out,
    output logic                         period_valid
);

    localparam int LAG_W   = $clog2(LAG_MAX + 1);
    localparam int OUT_MAX = (1 << DATA_W) - 1;

    state_t               r_state;
    state_t               w_state_nxt;
    slope_t               r_slope;
    slope_t               w_slope_nxt;
    logic [LAG_W-1:0]     r_lag_eff;
    logic [LAG_W-1:0]     w_lag_clamped;
    logic [LAG_W-1:0]     r_fill_cnt;
    logic [PERIOD_W-1:0]  r_period_cnt;
    logic                 r_have_peak;

    logic [DATA_W-1:0]    w_delayed;
    logic [DATA_W-1:0]    w_diff;
    logic                 w_sat;
    logic                 w_out_en;
    logic                 w_restart;
    logic                 w_peak;
    logic                 w_trough;
    int                   w_d_raw;
    int                   w_d;
    int                   w_r;

    logic [DATA_W-1:0]    r_diff_out;
    logic                 r_diff_valid;
    logic                 r_sat_flag;
    logic                 r_peak_flag;
    logic                 r_trough_flag;
    logic [PERIOD_W-1:0]  r_period_out;
    logic                 r_period_valid;

    lag_ring_buffer #(
        .DATA_W  (DATA_W),
        .LAG_MAX (LAG_MAX)
    ) u_ring (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .i_wr_en   (valid_in),
        .i_wr_data (wave_data),
        .i_lag_eff (r_lag_eff),
        .o_rd_data (w_delayed)
    );

    always_comb begin
        w_lag_clamped = lag;
        if (lag == '0) begin
            w_lag_clamped = LAG_W'(1);
        end else if (int'(lag) > LAG_MAX) begin
            w_lag_clamped = LAG_W'(LAG_MAX);
        end
    end

    // Output starts on the sample that completes the L_eff+1 fill.
    assign w_out_en  = valid_in &&
                       ((r_state == RUN) || ((r_state == FILL) && (r_fill_cnt == r_lag_eff)));
    assign w_restart = !valid_in && restart_on_gap && (r_state != IDLE);

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_restart) begin
                    w_state_nxt = IDLE;
                end else if (w_out_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_restart) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Difference arithmetic and slope tracking; slope ignores polarity.
    always_comb begin
        w_d_raw     = int'(wave_data) - int'(w_delayed);
        w_d         = invert ? -w_d_raw : w_d_raw;
        w_r         = w_d + MID_SCALE(DATA_W);
        w_sat       = (w_r < 0) || (w_r > OUT_MAX);
        w_diff      = DATA_W'(sat_clamp(w_r, OUT_MAX));
        w_slope_nxt = r_slope;
        if (w_d_raw > HYST) begin
            w_slope_nxt = RISING;
        end else if (w_d_raw < -HYST) begin
            w_slope_nxt = FALLING;
        end
        w_peak   = (r_slope == RISING)  && (w_slope_nxt == FALLING);
        w_trough = (r_slope == FALLING) && (w_slope_nxt == RISING);
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_lag_eff      <= LAG_W'(1);
            r_fill_cnt     <= '0;
            r_slope        <= UNKNOWN;
            r_period_cnt   <= '0;
            r_have_peak    <= 1'b0;
            r_diff_out     <= '0;
            r_diff_valid   <= 1'b0;
            r_sat_flag     <= 1'b0;
            r_peak_flag    <= 1'b0;
            r_trough_flag  <= 1'b0;
            r_period_out   <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_diff_valid   <= w_out_en;
            r_sat_flag     <= w_out_en && w_sat;
            r_peak_flag    <= w_out_en && w_peak;
            r_trough_flag  <= w_out_en && w_trough;
            r_period_valid <= 1'b0;
            if (w_out_en) begin
                r_diff_out <= w_diff;
            end

            if (w_restart) begin
                r_fill_cnt   <= '0;
                r_slope      <= UNKNOWN;
                r_period_cnt <= '0;
                r_have_peak  <= 1'b0;
            end else if (valid_in && (r_state == IDLE)) begin
                r_lag_eff  <= w_lag_clamped;
                r_fill_cnt <= LAG_W'(1);
            end else if (valid_in && (r_state == FILL) && !w_out_en) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            // A peak closes one period and opens the next with this sample as count 1.
            if (w_out_en) begin
                r_slope <= w_slope_nxt;
                if (w_peak) begin
                    r_period_cnt <= PERIOD_W'(1);
                    r_have_peak  <= 1'b1;
                    if (r_have_peak) begin
                        r_period_out   <= r_period_cnt;
                        r_period_valid <= 1'b1;
                    end
                end else if (r_period_cnt != '1) begin
                    r_period_cnt <= r_period_cnt + 1'b1;
                end
            end
        end
    end

    assign diff_out     = r_diff_out;
    assign diff_valid   = r_diff_valid;
    assign sat_flag     = r_sat_flag;
    assign peak_flag    = r_peak_flag;
    assign trough_flag  = r_trough_flag;
    assign period_out   = r_period_out;
    assign period_valid = r_period_valid;

endmodule

// File: tb/tb_wave_diff_tracker.sv
// Directed self-checking bench for wave_diff_tracker using immediate assertions.
module tb_wave_diff_tracker;

    localparam int DATA_W   = 8;
    localparam int LAG_MAX  = 16;
    localparam int HYST     = 4;
    localparam int PERIOD_W = 16;
    localparam int LAG_W    = $clog2(LAG_MAX + 1);

    logic                clk_50M = 1'b0;
    logic                rst_n;
    logic                valid_in;
    logic [DATA_W-1:0]   wave_data;
    logic [LAG_W-1:0]    lag;
    logic                invert;
    logic                restart_on_gap;
    logic [DATA_W-1:0]   diff_out;
    logic                diff_valid;
    logic                sat_flag;
    logic                peak_flag;
    logic                trough_flag;
    logic [PERIOD_W-1:0] period_out;
    logic                period_valid;

    int nAsserts  = 0;
    int nFailures = 0;

    always #10 clk_50M = ~clk_50M;

    wave_diff_tracker #(
        .DATA_W   (DATA_W),
        .LAG_MAX  (LAG_MAX),
        .HYST     (HYST),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk_50M        (clk_50M),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .wave_data      (wave_data),
        .lag            (lag),
        .invert         (invert),
        .restart_on_gap (restart_on_gap),
        .diff_out       (diff_out),
        .diff_valid     (diff_valid),
        .sat_flag       (sat_flag),
        .peak_flag      (peak_flag),
        .trough_flag    (trough_flag),
        .period_out     (period_out),
        .period_valid   (period_valid)
    );

    // Present one input cycle, then settle just after the capturing edge.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d);
        @(negedge clk_50M);
        valid_in  = v;
        wave_data = d;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFailures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkSample(input string tag, input logic expValid,
                               input logic [31:0] expDiff, input logic expSat);
        checkOutput({tag, "_valid"}, diff_valid, expValid);
        if (expValid) begin
            checkOutput({tag, "_diff"}, diff_out, expDiff);
            checkOutput({tag, "_sat"}, sat_flag, expSat);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        valid_in       = 1'b0;
        wave_data      = '0;
        lag            = LAG_W'(1);
        invert         = 1'b1;
        restart_on_gap = 1'b1;
        applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b1, 8'd50);
        checkOutput("rst_diff", diff_out, 0);
        checkOutput("rst_valid", diff_valid, 0);
        checkOutput("rst_sat", sat_flag, 0);
        checkOutput("rst_peak", peak_flag, 0);
        checkOutput("rst_trough", trough_flag, 0);
        checkOutput("rst_period", period_out, 0);
        checkOutput("rst_pvalid", period_valid, 0);

        rst_n = 1'b1;
        applyStimulus(1'b0, 8'd0);

        // Legacy polarity, lag 1
        applyStimulus(1'b1, 8'd100);
        checkSample("t1_s0", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd90);
        checkSample("t1_s1", 1'b1, 138, 1'b0);
        applyStimulus(1'b1, 8'd95);
        checkSample("t1_s2", 1'b1, 123, 1'b0);
        applyStimulus(1'b0, 8'd0);
        checkSample("t1_gap", 1'b0, 0, 1'b0);

        // Saturation at both rails
        invert = 1'b0;
        applyStimulus(1'b1, 8'd0);
        checkSample("t2_s0", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd255);
        checkSample("t2_hi", 1'b1, 255, 1'b1);
        applyStimulus(1'b1, 8'd0);
        checkSample("t2_lo", 1'b1, 0, 1'b1);
        applyStimulus(1'b0, 8'd0);

        // Lag 4 ramp across pointer wrap
        lag = LAG_W'(4);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, DATA_W'(i * 5));
            checkSample("t3_ramp", (i >= 4), 148, 1'b0);
        end
        applyStimulus(1'b0, 8'd0);

        // Gap with restart: refill required
        lag = LAG_W'(2);
        applyStimulus(1'b1, 8'd10);
        applyStimulus(1'b1, 8'd20);
        checkSample("t4a_s1", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd30);
        checkSample("t4a_s2", 1'b1, 148, 1'b0);
        applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b1, 8'd40);
        checkSample("t4a_n0", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd50);
        checkSample("t4a_n1", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd60);
        checkSample("t4a_n2", 1'b1, 148, 1'b0);
        applyStimulus(1'b0, 8'd0);

        // Gap without restart: history retained
        restart_on_gap = 1'b0;
        applyStimulus(1'b1, 8'd10);
        applyStimulus(1'b1, 8'd20);
        applyStimulus(1'b1, 8'd30);
        checkSample("t4b_s2", 1'b1, 148, 1'b0);
        applyStimulus(1'b0, 8'd0);
        checkSample("t4b_gap", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd50);
        checkSample("t4b_n0", 1'b1, 158, 1'b0);
        restart_on_gap = 1'b1;
        applyStimulus(1'b0, 8'd0);

        // Triangle wave, period 20 samples
        lag = LAG_W'(1);
        for (int k = 0; k <= 60; k++) begin
            int p;
            logic [DATA_W-1:0] v;
            p = k % 20;
            v = DATA_W'((p <= 10) ? p * 20 : (20 - p) * 20);
            applyStimulus(1'b1, v);
            checkOutput("t5_peak", peak_flag, (p == 11));
            checkOutput("t5_trough", trough_flag, (p == 1 && k > 11));
            checkOutput("t5_pvalid", period_valid, (p == 11 && k > 11));
            if (p == 11 && k > 11) begin
                checkOutput("t5_period", period_out, 20);
            end
            if (k > 0) begin
                checkSample("t5_diff", 1'b1, (p >= 1 && p <= 10) ? 148 : 108, 1'b0);
            end
        end

        // Reset mid-run clears outputs; lag 3 burst must refill
        @(negedge clk_50M);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'd77);
        checkOutput("t6_diff", diff_out, 0);
        checkOutput("t6_valid", diff_valid, 0);
        checkOutput("t6_period", period_out, 0);
        rst_n = 1'b1;
        lag   = LAG_W'(3);
        applyStimulus(1'b1, 8'd10);
        applyStimulus(1'b1, 8'd20);
        applyStimulus(1'b1, 8'd30);
        checkSample("t6_s2", 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd40);
        checkSample("t6_s3", 1'b1, 158, 1'b0);
        applyStimulus(1'b0, 8'd0);

        // Lag clamping: zero behaves as 1, oversize behaves as LAG_MAX
        lag = LAG_W'(0);
        applyStimulus(1'b1, 8'd5);
        applyStimulus(1'b1, 8'd9);
        checkSample("t7_lag0", 1'b1, 132, 1'b0);
        applyStimulus(1'b0, 8'd0);
        lag = LAG_W'(20);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, DATA_W'(i * 3));
            checkSample("t7_lagmax", (i >= 16), 176, 1'b0);
        end
        applyStimulus(1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
        $finish;
    end

endmodule
